// File: rtl/usb_ep_pkg.sv
// Shared types and helpers for the USB endpoint application-side blocks.
package usb_ep_pkg;

  localparam int unsigned BYTE_W = 8;

  // Loopback client sequencing: drain host packet, ack it, echo it back.
  typedef enum logic [2:0] {
    IDLE,
    POP,
    POP_DONE,
    FILL,
    FILL_DONE,
    FILL_ABORT
  } LoopbackState;

  // Address width for an n-entry array; at least one bit so ports never collapse.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usb_ep_packet_buffer.sv
// Single-packet byte store for the loopback client.
// Ports: clk; write port (wr_en, wr_idx, wr_data) captured on the rising edge;
// read port (rd_idx -> rd_data) is combinational.
module usb_ep_packet_buffer
  import usb_ep_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // Payload storage needs no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/usb_ep_loopback.sv
// Application-side echo client for one endpoint pair: pops a complete
// host->device packet from EP_IN, XORs each byte with XOR_MASK and fills it
// back to EP_OUT as one device->host packet, retrying the whole packet when
// the controller stays full for FULL_TIMEOUT consecutive cycles.
// Ports: clk12_i/rst_i (async active-high); EP_IN pop handshake
// (dataAvailable_i, data_i, popData_o, popTransDone_o, popTransSuccess_o);
// EP_OUT fill handshake (full_i, dataValid_o, data_o, fillTransDone_o,
// fillTransSuccess_o); status pktCount_o, overflow_o (sticky), busy_o.
module usb_ep_loopback
  import usb_ep_pkg::*;
#(
  parameter int unsigned MAX_PACKET_BYTES = 64,
  parameter logic [7:0]  XOR_MASK         = 8'h00,
  parameter int unsigned FULL_TIMEOUT     = 1024,
  parameter int unsigned CNT_WIDTH        = 16
) (
  input  logic                 clk12_i,
  input  logic                 rst_i,
  input  logic                 EP_IN_dataAvailable_i,
  input  logic [BYTE_W-1:0]    EP_IN_data_i,
  output logic                 EP_IN_popData_o,
  output logic                 EP_IN_popTransDone_o,
  output logic                 EP_IN_popTransSuccess_o,
  input  logic                 EP_OUT_full_i,
  output logic                 EP_OUT_dataValid_o,
  output logic [BYTE_W-1:0]    EP_OUT_data_o,
  output logic                 EP_OUT_fillTransDone_o,
  output logic                 EP_OUT_fillTransSuccess_o,
  output logic [CNT_WIDTH-1:0] pktCount_o,
  output logic                 overflow_o,
  output logic                 busy_o
);

  localparam int unsigned IDX_W  = $clog2(MAX_PACKET_BYTES + 1);
  localparam int unsigned TO_W   = $clog2(FULL_TIMEOUT + 1);
  localparam int unsigned ADDR_W = idx_width(MAX_PACKET_BYTES);

  LoopbackState         state, state_nxt;
  logic [IDX_W-1:0]     wr_cnt, wr_cnt_nxt;
  logic [IDX_W-1:0]     rd_idx, rd_idx_nxt;
  logic [TO_W-1:0]      timeout, timeout_nxt;
  logic [CNT_WIDTH-1:0] pkt_count, pkt_count_nxt;
  logic                 overflow, overflow_nxt;

  logic                 pop_c, pop_done_c, fill_valid_c, fill_done_c, fill_ok_c;
  logic                 buf_wr_en_c;
  logic [BYTE_W-1:0]    buf_rd_data;

  usb_ep_packet_buffer #(
    .DEPTH  (MAX_PACKET_BYTES),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk     (clk12_i),
    .wr_en   (buf_wr_en_c),
    .wr_idx  (ADDR_W'(wr_cnt)),
    .wr_data (EP_IN_data_i),
    .rd_idx  (ADDR_W'(rd_idx)),
    .rd_data (buf_rd_data)
  );

  // State and counter registers.
  always_ff @(posedge clk12_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      wr_cnt    <= '0;
      rd_idx    <= '0;
      timeout   <= '0;
      pkt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_cnt    <= wr_cnt_nxt;
      rd_idx    <= rd_idx_nxt;
      timeout   <= timeout_nxt;
      pkt_count <= pkt_count_nxt;
      overflow  <= overflow_nxt;
    end
  end

  // Next-state, counter updates and handshake decode.
  always_comb begin
    state_nxt     = state;
    wr_cnt_nxt    = wr_cnt;
    rd_idx_nxt    = rd_idx;
    timeout_nxt   = timeout;
    pkt_count_nxt = pkt_count;
    overflow_nxt  = overflow;
    pop_c         = 1'b0;
    pop_done_c    = 1'b0;
    fill_valid_c  = 1'b0;
    fill_done_c   = 1'b0;
    fill_ok_c     = 1'b0;
    buf_wr_en_c   = 1'b0;

    case (state)
      IDLE: begin
        if (EP_IN_dataAvailable_i) begin
          state_nxt  = POP;
          wr_cnt_nxt = '0;
        end
      end
      POP: begin
        pop_c = EP_IN_dataAvailable_i;
        if (EP_IN_dataAvailable_i) begin
          // Bytes past the buffer are still consumed so the controller drains.
          if (wr_cnt < IDX_W'(MAX_PACKET_BYTES)) begin
            buf_wr_en_c = 1'b1;
            wr_cnt_nxt  = wr_cnt + IDX_W'(1);
          end else begin
            overflow_nxt = 1'b1;
          end
        end else begin
          state_nxt = POP_DONE;
        end
      end
      POP_DONE: begin
        pop_done_c  = 1'b1;
        rd_idx_nxt  = '0;
        timeout_nxt = '0;
        state_nxt   = FILL;
      end
      FILL: begin
        fill_valid_c = 1'b1;
        // An accept always clears the timeout, so it wins over expiry.
        if (!EP_OUT_full_i) begin
          rd_idx_nxt  = rd_idx + IDX_W'(1);
          timeout_nxt = '0;
          if (rd_idx == wr_cnt - IDX_W'(1)) state_nxt = FILL_DONE;
        end else if (timeout == TO_W'(FULL_TIMEOUT - 1)) begin
          state_nxt = FILL_ABORT;
        end else begin
          timeout_nxt = timeout + TO_W'(1);
        end
      end
      FILL_DONE: begin
        fill_done_c   = 1'b1;
        fill_ok_c     = 1'b1;
        pkt_count_nxt = pkt_count + CNT_WIDTH'(1);
        state_nxt     = IDLE;
      end
      FILL_ABORT: begin
        // Buffer is kept; the whole packet is offered again from byte 0.
        fill_done_c = 1'b1;
        rd_idx_nxt  = '0;
        timeout_nxt = '0;
        state_nxt   = FILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign EP_IN_popData_o           = pop_c;
  assign EP_IN_popTransDone_o      = pop_done_c;
  assign EP_IN_popTransSuccess_o   = pop_done_c;
  assign EP_OUT_dataValid_o        = fill_valid_c;
  // Gated so the data bus reads zero whenever no byte is offered.
  assign EP_OUT_data_o             = fill_valid_c ? (buf_rd_data ^ XOR_MASK) : '0;
  assign EP_OUT_fillTransDone_o    = fill_done_c;
  assign EP_OUT_fillTransSuccess_o = fill_ok_c;
  assign pktCount_o                = pkt_count;
  assign overflow_o                = overflow;
  assign busy_o                    = (state != IDLE);

endmodule

// File: tb/tb_usb_ep_loopback.sv
// Self-checking bench for usb_ep_loopback: a controller-side driver feeds
// packets and back-pressure, and a packet-level reference model predicts every
// handshake output each cycle.
module tb_usb_ep_loopback;

  localparam int unsigned MAXB = 64;
  localparam logic [7:0]  MASK = 8'hFF;
  localparam int unsigned FT   = 16;
  localparam int unsigned CW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          avail;
  logic [7:0]    din;
  logic          full;
  logic          pop, pdone, psucc, valid, fdone, fsucc, ovf, busy;
  logic [7:0]    dout;
  logic [CW-1:0] cnt;

  always #5 clk = ~clk;

  usb_ep_loopback #(
    .MAX_PACKET_BYTES (MAXB),
    .XOR_MASK         (MASK),
    .FULL_TIMEOUT     (FT),
    .CNT_WIDTH        (CW)
  ) dut (
    .clk12_i                   (clk),
    .rst_i                     (rst),
    .EP_IN_dataAvailable_i     (avail),
    .EP_IN_data_i              (din),
    .EP_IN_popData_o           (pop),
    .EP_IN_popTransDone_o      (pdone),
    .EP_IN_popTransSuccess_o   (psucc),
    .EP_OUT_full_i             (full),
    .EP_OUT_dataValid_o        (valid),
    .EP_OUT_data_o             (dout),
    .EP_OUT_fillTransDone_o    (fdone),
    .EP_OUT_fillTransSuccess_o (fsucc),
    .pktCount_o                (cnt),
    .overflow_o                (ovf),
    .busy_o                    (busy)
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Controller-side state and observations.
  logic [7:0] in_q[$];
  logic [7:0] got_q[$];
  bit         consumed = 1'b0;
  bit         rand_full = 1'b0;
  bit         ok_seen = 1'b0;
  int         acc_pos = 0, pop_cnt = 0, abort_cnt = 0, pdone_cnt = 0;
  int         hold_idx = 0, hold_left = 0, n_sent = 0;

  // Reference model: packet-level phases of the echo transaction.
  typedef enum int {M_IDLE, M_RX, M_RX_ACK, M_TX, M_TX_OK, M_TX_ABORT} mph_t;
  mph_t       mph = M_IDLE;
  logic [7:0] rx_q[$];
  logic [7:0] echo_q[$];
  int         pos = 0, run = 0;
  logic [CW-1:0] m_cnt = '0;
  logic       m_ovf = 1'b0;

  // Compare and advance the model at mid-cycle, when inputs and outputs are settled.
  always @(negedge clk) begin : compare_proc
    logic [7:0] ef, af;
    if (rst) begin
      chk("reset_outputs", 64'({pop, pdone, psucc, valid, dout, fdone, fsucc, cnt, ovf, busy}), 64'd0);
      mph = M_IDLE; rx_q.delete(); echo_q.delete(); pos = 0; run = 0;
      m_cnt = '0; m_ovf = 1'b0; consumed = 1'b0; acc_pos = 0;
    end else begin
      ef = {mph == M_RX && avail, mph == M_RX_ACK, mph == M_RX_ACK, mph == M_TX,
            mph == M_TX_OK || mph == M_TX_ABORT, mph == M_TX_OK, mph != M_IDLE, m_ovf};
      af = {pop, pdone, psucc, valid, fdone, fsucc, busy, ovf};
      chk("ctrl_flags", 64'(af), 64'(ef));
      chk("pkt_count", 64'(cnt), 64'(m_cnt));
      if (mph == M_TX) chk("echo_byte", 64'(dout), 64'(echo_q[pos]));

      consumed = pop && avail;
      if (consumed) pop_cnt++;
      if (pdone && psucc) pdone_cnt++;
      if (valid && !full) begin got_q.push_back(dout); acc_pos++; end
      if (fdone) begin
        acc_pos = 0;
        if (fsucc) ok_seen = 1'b1;
        else begin abort_cnt++; got_q.delete(); end
      end

      case (mph)
        M_IDLE: if (avail) mph = M_RX;
        M_RX: begin
          if (avail) begin
            if (rx_q.size() < int'(MAXB)) rx_q.push_back(din);
            else m_ovf = 1'b1;
          end else mph = M_RX_ACK;
        end
        M_RX_ACK: begin
          echo_q.delete();
          foreach (rx_q[i]) echo_q.push_back(rx_q[i] ^ MASK);
          pos = 0; run = 0; mph = M_TX;
        end
        M_TX: begin
          if (!full) begin
            pos++; run = 0;
            if (pos == echo_q.size()) mph = M_TX_OK;
          end else begin
            run++;
            if (run == int'(FT)) mph = M_TX_ABORT;
          end
        end
        M_TX_OK: begin m_cnt = CW'(m_cnt + 1'b1); rx_q.delete(); mph = M_IDLE; end
        M_TX_ABORT: begin pos = 0; run = 0; mph = M_TX; end
        default: mph = M_IDLE;
      endcase
    end
  end

  // Advance one clock and drive this cycle's controller inputs.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (consumed && in_q.size() != 0) void'(in_q.pop_front());
    avail = (in_q.size() != 0);
    din   = avail ? in_q[0] : 8'($urandom);
    full  = 1'b0;
    if (hold_left > 0 && valid && acc_pos == hold_idx) begin
      full = 1'b1;
      hold_left--;
    end else if (rand_full) begin
      full = ($urandom_range(0, 3) == 0);
    end
  endtask

  // Run the packet loaded into in_q until its successful fill commit.
  task automatic run_pkt(input string name);
    int budget;
    got_q.delete(); abort_cnt = 0; pop_cnt = 0; pdone_cnt = 0; ok_seen = 1'b0;
    budget = 3000;
    while (!ok_seen && budget > 0) begin
      cycle();
      budget--;
    end
    chk({name, "_done"}, 64'(ok_seen), 64'd1);
    n_sent++;
  endtask

  function automatic logic [63:0] got_word(input int n);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < n; i++) begin
      w = w << 8;
      if (i < got_q.size()) w[7:0] = got_q[i];
    end
    return w;
  endfunction

  initial begin
    logic [7:0] ref_b[$];
    int len, lim, bad, budget;
    rst = 1'b1; avail = 1'b0; din = 8'h00; full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic three-byte echo.
    in_q = '{8'h11, 8'h22, 8'h33};
    run_pkt("basic");
    chk("basic_echo", got_word(3), 64'h00EE_DDCC);
    chk("basic_len", 64'(got_q.size()), 64'd3);
    chk("basic_pops", 64'(pop_cnt), 64'd3);
    chk("basic_popdone", 64'(pdone_cnt), 64'd1);
    chk("basic_count", 64'(cnt), 64'd1);

    // Mask inverts every bit.
    in_q = '{8'h0F, 8'hA5};
    run_pkt("mask");
    chk("mask_echo", got_word(2), 64'h0000_F05A);
    chk("mask_count", 64'(cnt), 64'd2);

    // Oversized packet: all popped, first MAXB echoed, overflow sticks.
    ref_b.delete();
    for (int i = 0; i < 70; i++) ref_b.push_back(8'($urandom));
    in_q = ref_b;
    run_pkt("ovf");
    chk("ovf_pops", 64'(pop_cnt), 64'd70);
    chk("ovf_len", 64'(got_q.size()), 64'd64);
    bad = 0;
    for (int i = 0; i < 64 && i < got_q.size(); i++) if (got_q[i] !== (ref_b[i] ^ MASK)) bad++;
    chk("ovf_bytes", 64'(bad), 64'd0);
    chk("ovf_flag", 64'(ovf), 64'd1);
    in_q = '{8'h3C};
    run_pkt("ovf_next");
    chk("ovf_next_echo", got_word(1), 64'h0000_00C3);
    chk("ovf_sticky", 64'(ovf), 64'd1);

    // Short back-pressure on byte 1: byte held, no skip or repeat.
    in_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    hold_idx = 1; hold_left = 3;
    run_pkt("stall");
    chk("stall_echo", got_word(4), 64'h5F5E_5D5C);
    chk("stall_aborts", 64'(abort_cnt), 64'd0);
    chk("stall_applied", 64'(hold_left), 64'd0);

    // FT full cycles on byte 2 abort once, then the whole packet goes through.
    in_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    hold_idx = 2; hold_left = 16;
    run_pkt("abort");
    chk("abort_count", 64'(abort_cnt), 64'd1);
    chk("abort_echo", got_word(4), 64'hEFDF_CFBF);

    // One cycle short of the timeout must not abort.
    in_q = '{8'h01, 8'h02};
    hold_idx = 0; hold_left = 15;
    run_pkt("edge");
    chk("edge_aborts", 64'(abort_cnt), 64'd0);
    chk("edge_echo", got_word(2), 64'h0000_FEFD);

    // Random lengths, random back-pressure and occasional long stalls.
    rand_full = 1'b1;
    for (int p = 0; p < 20; p++) begin
      len = int'($urandom_range(1, 80));
      lim = (len < int'(MAXB)) ? len : int'(MAXB);
      in_q.delete();
      for (int i = 0; i < len; i++) in_q.push_back(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        hold_idx  = int'($urandom_range(0, lim - 1));
        hold_left = int'($urandom_range(10, 20));
      end else hold_left = 0;
      run_pkt("rand");
    end
    rand_full = 1'b0; hold_left = 0;
    chk("wrap_count", 64'(cnt), 64'(n_sent % 16));

    // Reset in the middle of a fill drops everything at once.
    in_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    hold_idx = 3; hold_left = 5;
    got_q.delete(); ok_seen = 1'b0;
    budget = 200;
    while (!(acc_pos == 3 && valid) && budget > 0) begin cycle(); budget--; end
    chk("rst_reached_fill", 64'(valid), 64'd1);
    #1 rst = 1'b1;
    #1 chk("rst_outputs_zero", 64'({pop, pdone, psucc, valid, dout, fdone, fsucc, cnt, ovf, busy}), 64'd0);
    in_q.delete(); hold_left = 0;
    cycle(); cycle();
    rst = 1'b0;
    n_sent = 0;
    in_q = '{8'h7E};
    run_pkt("post_rst");
    chk("post_rst_echo", got_word(1), 64'h0000_0081);
    chk("post_rst_count", 64'(cnt), 64'd1);
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
